// File: rtl/mem_word_assembler_pkg.sv
// Shared constants for the two-beat word assembler: FSM encodings and the
// default beat/address widths used by the memory module.
package mem_word_assembler_pkg;

  localparam int DEFAULT_SIZE       = 8;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ0  = 3'd1;
  localparam logic [2:0] ST_WAIT0 = 3'd2;
  localparam logic [2:0] ST_REQ1  = 3'd3;
  localparam logic [2:0] ST_WAIT1 = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ0  = ST_REQ0,
    S_WAIT0 = ST_WAIT0,
    S_REQ1  = ST_REQ1,
    S_WAIT1 = ST_WAIT1,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mem_word_assembler_if.sv
// Handshake bundle between the fetch requester / byte memory and the word
// assembler. Parity signals exist only when WORD_ASM_PARITY_EN is defined.
interface mem_word_assembler_if
  import mem_word_assembler_pkg::*;
#(
  parameter int size      = DEFAULT_SIZE,
  parameter int addrWidth = DEFAULT_ADDR_WIDTH
) ();

  logic                   start;
  logic [addrWidth-1:0]   baseAddr;
  logic                   halfSel;
  logic [addrWidth-1:0]   memAddr;
  logic                   memRead;
  logic [size-1:0]        memData;
  logic                   memValid;
  logic [2*size-1:0]      inputVal;
  logic                   sel;
  logic                   wordValid;
  logic                   busy;
`ifdef WORD_ASM_PARITY_EN
  logic                   memParity;
  logic                   parityErr;

  modport master (
    output start, baseAddr, halfSel, memData, memValid, memParity,
    input  memAddr, memRead, inputVal, sel, wordValid, busy, parityErr
  );

  modport slave (
    input  start, baseAddr, halfSel, memData, memValid, memParity,
    output memAddr, memRead, inputVal, sel, wordValid, busy, parityErr
  );
`else
  modport master (
    output start, baseAddr, halfSel, memData, memValid,
    input  memAddr, memRead, inputVal, sel, wordValid, busy
  );

  modport slave (
    input  start, baseAddr, halfSel, memData, memValid,
    output memAddr, memRead, inputVal, sel, wordValid, busy
  );
`endif

endinterface

// File: rtl/mem_word_assembler_beat_capture.sv
// Registers one memory beat into the low or high half of the assembled word.
// With WORD_ASM_PARITY_EN it also keeps a sticky even-parity error flag.
module beat_capture #(
  parameter int size = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cap_en,
  input  logic              i_cap_hi,
  input  logic [size-1:0]   i_data,
`ifdef WORD_ASM_PARITY_EN
  input  logic              i_parity,
  input  logic              i_par_clr,
  output logic              o_par_err,
`endif
  output logic [2*size-1:0] o_word
);

  logic [2*size-1:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_cap_en) begin
      if (i_cap_hi) r_word[2*size-1:size] <= i_data;
      else          r_word[size-1:0]      <= i_data;
    end
  end

  assign o_word = r_word;

`ifdef WORD_ASM_PARITY_EN
  logic w_par_bad;
  logic r_par_err;

  // Even parity: the parity bit equals the XOR of the data bits.
  assign w_par_bad = (^i_data) != i_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (i_par_clr) begin
      r_par_err <= 1'b0;
    end else if (i_cap_en && w_par_bad) begin
      r_par_err <= 1'b1;
    end
  end

  assign o_par_err = r_par_err;
`endif

endmodule

// File: rtl/mem_word_assembler.sv
// Two-beat word assembler: reads base and base+1 from a byte-wide memory and
// presents {high, low} plus mux select. Optional parity: WORD_ASM_PARITY_EN.
//   state | meaning
//   IDLE  | waiting for start
//   REQ0  | low-beat read strobe out
//   WAIT0 | waiting for low beat
//   REQ1  | high-beat read strobe out
//   WAIT1 | waiting for high beat
//   DONE  | wordValid pulse
module mem_word_assembler
  import mem_word_assembler_pkg::*;
#(
  parameter int size      = DEFAULT_SIZE,
  parameter int addrWidth = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_word_assembler_if.slave   bus
);

  state_t                 r_state;
  logic [addrWidth-1:0]   r_mem_addr;
  logic                   r_mem_read;
  logic                   r_sel;
  logic                   r_word_valid;
  logic                   r_busy;
  logic                   w_cap_en;
  logic                   w_cap_hi;
  logic [2*size-1:0]      w_word;

  assign w_cap_en = bus.memValid && (r_state == S_WAIT0 || r_state == S_WAIT1);
  assign w_cap_hi = (r_state == S_WAIT1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_sel        <= 1'b0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_read   <= 1'b0;
      r_word_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mem_addr <= bus.baseAddr;
            r_sel      <= bus.halfSel;
            r_mem_read <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_REQ0;
          end
        end
        S_REQ0:  r_state <= S_WAIT0;
        S_WAIT0: begin
          if (bus.memValid) begin
            // Wraps modulo 2^addrWidth.
            r_mem_addr <= r_mem_addr + {{(addrWidth-1){1'b0}}, 1'b1};
            r_mem_read <= 1'b1;
            r_state    <= S_REQ1;
          end
        end
        S_REQ1:  r_state <= S_WAIT1;
        S_WAIT1: begin
          if (bus.memValid) begin
            r_word_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WORD_ASM_PARITY_EN
  logic w_par_clr;
  logic w_par_err;

  assign w_par_clr = (r_state == S_IDLE) && bus.start;
`endif

  beat_capture #(.size(size)) u_beat_capture (
    .clk       (clk),
    .rst       (rst),
    .i_cap_en  (w_cap_en),
    .i_cap_hi  (w_cap_hi),
    .i_data    (bus.memData),
`ifdef WORD_ASM_PARITY_EN
    .i_parity  (bus.memParity),
    .i_par_clr (w_par_clr),
    .o_par_err (w_par_err),
`endif
    .o_word    (w_word)
  );

  assign bus.memAddr   = r_mem_addr;
  assign bus.memRead   = r_mem_read;
  assign bus.inputVal  = w_word;
  assign bus.sel       = r_sel;
  assign bus.wordValid = r_word_valid;
  assign bus.busy      = r_busy;
`ifdef WORD_ASM_PARITY_EN
  assign bus.parityErr = w_par_err;
`endif

endmodule
